// File: rtl/memory_loader_pkg.sv
// Shared widths, FSM encoding and chunk-placement helper for the 7-bit to
// 35-bit memory loader.
package memory_loader_pkg;

    localparam int CHUNK_W = 7;
    localparam int NCHUNK  = 5;
    localparam int WORD_W  = CHUNK_W * NCHUNK;
    localparam int CNT_W   = 16;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    // Returns word with chunk placed in slot idx; other slots are untouched.
    function automatic logic [WORD_W-1:0] insert_chunk(
        input logic [WORD_W-1:0]  word,
        input logic [IDX_W-1:0]   idx,
        input logic [CHUNK_W-1:0] chunk
    );
        logic [WORD_W-1:0] res;
        res = word;
        for (int k = 0; k < NCHUNK; k++) begin
            res[k*CHUNK_W +: CHUNK_W] = (idx == IDX_W'(k)) ? chunk
                                                           : word[k*CHUNK_W +: CHUNK_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/memory_loader.sv
// Assembles five 7-bit chunks (LS chunk first) into a 35-bit word and issues a
// one-cycle write strobe to the downstream memory unit; flags framing errors.
module memory_loader
    import memory_loader_pkg::*;
(
    input  logic               clk,
    input  logic               srstn,
    input  logic               in_valid,
    input  logic [CHUNK_W-1:0] in_data,
    input  logic               in_last,
    output logic               in_ready,
    input  logic               abort,
    output logic               wren,
    output logic [WORD_W-1:0]  dout,
    output logic               err,
    output logic [CNT_W-1:0]   word_cnt
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  asm_q, asm_d;
    logic [WORD_W-1:0]  dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wren_q, wren_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;

    logic               accept_s;
    logic               last_idx_s;
    logic               commit_s;
    logic               frame_err_s;

    // A transfer needs the handshake and no abort; abort wins over the chunk.
    assign accept_s    = in_valid & ready_q & ~abort;
    assign last_idx_s  = (idx_q == IDX_W'(NCHUNK - 1));
    assign commit_s    = accept_s & last_idx_s & in_last;
    assign frame_err_s = accept_s & (in_last != last_idx_s);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            asm_q   <= {WORD_W{1'b0}};
            dout_q  <= {WORD_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            wren_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (abort || frame_err_s) begin
                    state_d = ST_IDLE;
                end else if (accept_s) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (abort || frame_err_s) begin
                    state_d = ST_IDLE;
                end else if (commit_s) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values; the partial word is cleared whenever a word ends.
    always_comb begin
        idx_d   = idx_q;
        asm_d   = asm_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        wren_d  = 1'b0;
        err_d   = 1'b0;
        ready_d = (state_d != ST_COMMIT);
        if (abort || frame_err_s || (state_q == ST_COMMIT)) begin
            idx_d = {IDX_W{1'b0}};
            asm_d = {WORD_W{1'b0}};
            err_d = frame_err_s;
        end else if (commit_s) begin
            idx_d  = {IDX_W{1'b0}};
            asm_d  = {WORD_W{1'b0}};
            dout_d = insert_chunk(asm_q, idx_q, in_data);
            wren_d = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
        end else if (accept_s) begin
            idx_d = idx_q + IDX_W'(1);
            asm_d = insert_chunk(asm_q, idx_q, in_data);
        end else begin
            idx_d = idx_q;
            asm_d = asm_q;
        end
    end

    assign in_ready = ready_q;
    assign wren     = wren_q;
    assign err      = err_q;
    assign dout     = dout_q;
    assign word_cnt = cnt_q;

endmodule
